// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
//   Shared constants and types for the rotational CORDIC front end.
//   THETA_W      width of angle / residual words
//   ANG_FRAC     fraction bits of the radian output (2^14 = 1 rad) and of the
//                quarter-turn in binary angle units (2^14 = pi/2)
//   PI_HALF_Q    round(pi/2 * 2^14), radians per quarter turn
//   QUARTER_TURN binary angle of +pi/2
//   quad_t       quadrant code taken from the two angle MSBs
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int THETA_W  = 16;
  localparam int ANG_FRAC = 14;
  localparam int PI_HALF_Q = 25736;

  localparam logic signed [THETA_W-1:0] QUARTER_TURN = 16'sd16384;

  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b10,
    Q3 = 2'b11
  } quad_t;

endpackage

// File: rtl/rotational_cordic_prerotate_if.sv
// -----------------------------------------------------------------------------
// rotational_cordic_prerotate_if
//   Stream bus of the CORDIC pre-rotation stage: one input beat channel
//   (vector + binary angle) and one output beat channel (pre-rotated vector,
//   residual angle in radians, quadrant).
//   slave  : the pre-rotation block (consumes input beats, produces output)
//   master : the environment driving beats in and accepting them out
// -----------------------------------------------------------------------------
interface rotational_cordic_prerotate_if
  import cordic_pkg::*;
#(
  parameter int N = 15
);

  // input channel
  logic                      in_valid;
  logic                      in_ready;
  logic signed [N:0]         x_in;
  logic signed [N:0]         y_in;
  logic signed [THETA_W-1:0] ang_in;

  // output channel
  logic                      out_valid;
  logic                      out_ready;
  logic signed [N:0]         x_out;
  logic signed [N:0]         y_out;
  logic signed [THETA_W-1:0] theta_out;
  logic [1:0]                quad_out;

  modport slave (
    input  in_valid, x_in, y_in, ang_in, out_ready,
    output in_ready, out_valid, x_out, y_out, theta_out, quad_out
  );

  modport master (
    output in_valid, x_in, y_in, ang_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, theta_out, quad_out
  );

endinterface

// File: rtl/cordic_pipe_reg.sv
// -----------------------------------------------------------------------------
// cordic_pipe_reg
//   One valid/ready pipeline register holding a payload of type T.
//   The register loads whenever it is empty or its content is being taken
//   downstream in the same cycle, so bubbles collapse and a full pipeline keeps
//   one beat per cycle. in_ready is combinational from out_ready.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid/in_ready     upstream handshake,  in_data  payload in
//     out_valid/out_ready   downstream handshake, out_data payload out
// -----------------------------------------------------------------------------
module cordic_pipe_reg #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_r;
  T     data_r;

  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Stage register: take a new beat (or a bubble) whenever the slot frees up;
  // payload only changes on a real beat so a drained register keeps its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/rotational_cordic_prerotate.sv
// -----------------------------------------------------------------------------
// rotational_cordic_prerotate
//   Input stage of the rotational CORDIC pipeline, directly upstream of stage 0.
//   S1 folds the full-circle binary angle into [-pi/2, pi/2) with an exact
//   +-90 degree vector rotation; S2 converts the residual binary angle to
//   radians at 2^14 = 1 rad. Two registered stages with valid/ready flow
//   control; latency 2, throughput 1 beat per cycle.
//   Parameters:
//     N          data MSB index (x/y are N+1 bits signed)
//     PI_HALF_Q  round(pi/2 * 2^14)
//     ROUND      1: round-half-up on radian conversion, 0: floor
//   Ports:
//     clk    single clock, all state on posedge
//     reset  synchronous, active-high; drops every in-flight beat
//     bus    stream interface (slave side): in_valid/in_ready, x_in, y_in,
//            ang_in (2^15 = pi) -> out_valid/out_ready, x_out, y_out,
//            theta_out (2^14 = 1 rad), quad_out (ang_in[15:14] of the beat)
// -----------------------------------------------------------------------------
module rotational_cordic_prerotate
  import cordic_pkg::*;
#(
  parameter int N         = 15,
  parameter int PI_HALF_Q = cordic_pkg::PI_HALF_Q,
  parameter bit ROUND     = 1'b1
) (
  input logic                          clk,
  input logic                          reset,
  rotational_cordic_prerotate_if.slave bus
);

  // One beat through the pipe. In S1 `ang` is the residual binary angle,
  // in S2 the same field carries the converted radian value.
  typedef struct packed {
    logic signed [N:0]         x;
    logic signed [N:0]         y;
    logic signed [THETA_W-1:0] ang;
    quad_t                     quad;
  } beat_t;

  localparam logic signed [31:0] PI_HALF_W = 32'(PI_HALF_Q);
  // Half an output LSB before the shift turns floor into round-half-up.
  localparam logic signed [31:0] RND_W     = ROUND ? 32'sd8192 : 32'sd0;

  // Two's complement negation with the single overflow case clamped:
  // -(-2^N) becomes 2^N - 1.
  function automatic logic signed [N:0] sat_neg(input logic signed [N:0] v);
    logic signed [N:0] most_neg;
    most_neg = {1'b1, {N{1'b0}}};
    if (v == most_neg) begin
      return {1'b0, {N{1'b1}}};
    end else begin
      return -v;
    end
  endfunction

  quad_t              quad_s;
  beat_t              s1_in_s;
  beat_t              s1_out_s;
  beat_t              s2_in_s;
  beat_t              s2_out_s;
  logic               s1_valid_s;
  logic               s2_ready_s;
  logic signed [31:0] ang_ext_s;
  logic signed [31:0] prod_s;
  logic signed [31:0] sum_s;
  logic               unused_sum_bits_s;

  // Fold: quadrants 01 and 10 are rotated by -/+90 degrees so the residual
  // stays inside [-pi/2, pi/2); quadrants 00 and 11 already are.
  always_comb begin
    quad_s       = quad_t'(bus.ang_in[THETA_W-1 -: 2]);
    s1_in_s.quad = quad_s;
    s1_in_s.x    = bus.x_in;
    s1_in_s.y    = bus.y_in;
    s1_in_s.ang  = bus.ang_in;
    case (quad_s)
      Q1: begin
        s1_in_s.x   = sat_neg(bus.y_in);
        s1_in_s.y   = bus.x_in;
        s1_in_s.ang = bus.ang_in - QUARTER_TURN;
      end
      Q2: begin
        s1_in_s.x   = bus.y_in;
        s1_in_s.y   = sat_neg(bus.x_in);
        s1_in_s.ang = bus.ang_in + QUARTER_TURN;
      end
      Q0, Q3: begin
        s1_in_s.x   = bus.x_in;
        s1_in_s.y   = bus.y_in;
        s1_in_s.ang = bus.ang_in;
      end
      default: begin
        s1_in_s.x   = bus.x_in;
        s1_in_s.y   = bus.y_in;
        s1_in_s.ang = bus.ang_in;
      end
    endcase
  end

  cordic_pipe_reg #(
    .T (beat_t)
  ) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_out_s)
  );

  // Convert: residual quarter-turn fraction times pi/2 gives radians; the
  // residual is bounded by 2^14 so the product fits 32 bits and the shifted
  // result fits 16 bits without saturation.
  always_comb begin
    ang_ext_s         = {{(32-THETA_W){s1_out_s.ang[THETA_W-1]}}, s1_out_s.ang};
    prod_s            = ang_ext_s * PI_HALF_W;
    sum_s             = prod_s + RND_W;
    s2_in_s.x         = s1_out_s.x;
    s2_in_s.y         = s1_out_s.y;
    s2_in_s.quad      = s1_out_s.quad;
    // bits [ANG_FRAC +: THETA_W] are exactly (sum >>> ANG_FRAC) truncated
    s2_in_s.ang       = sum_s[ANG_FRAC +: THETA_W];
    unused_sum_bits_s = ^{sum_s[31:ANG_FRAC+THETA_W], sum_s[ANG_FRAC-1:0]};
  end

  cordic_pipe_reg #(
    .T (beat_t)
  ) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_out_s)
  );

  // outputs come straight from the S2 register
  assign bus.x_out     = s2_out_s.x;
  assign bus.y_out     = s2_out_s.y;
  assign bus.theta_out = s2_out_s.ang;
  assign bus.quad_out  = s2_out_s.quad;

endmodule
